pc_redirect_unit: RTL

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_redirect_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_unit
//  Purpose  : Fetch program-counter sequencer. Advances the fetch address by 4
//             when instruction memory accepts it, honours hazard stalls, and
//             applies branch redirects. A redirect that arrives while memory is
//             not ready is parked in a pending register until memory accepts.
//             A misaligned redirect target locks the unit into a trap state
//             that only reset leaves.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             PcSel, BrPC       - redirect request and 32-bit target
//             Stall             - hazard hold request (ignored while a redirect
//                                 is pending)
//             imem_ready        - memory accepts the current fetch address
//             Cur_PC            - registered fetch address (PC_W bits)
//             imem_req          - fetch request (low only in trap)
//             Flush             - pipeline squash, FLUSH_CYC cycles per redirect
//             Trap              - sticky misaligned-target flag
//             RedirectCount     - saturating count of accepted redirects
//  Options  : PC_REDIRECT_STATS_EN - when defined, builds the RedirectCount
//             counter; otherwise RedirectCount is constant zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic            imem_ready,
  output logic [PC_W-1:0] Cur_PC,
  output logic            imem_req,
  output logic            Flush,
  output logic            Trap,
  output logic [15:0]     RedirectCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    TRAP     = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] c_reset_pc  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] c_pc_step   = PC_W'(4);
  localparam logic [1:0]      c_flush_cyc = 2'(FLUSH_CYC);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            trap_q, trap_d;
  logic            accept;

  logic [PC_W-1:0] target;
  logic            misaligned;

  // Upper target bits are architecturally don't-care.
  logic unused_brpc_hi;
  assign unused_brpc_hi = &{1'b0, BrPC[31:PC_W]};

  assign target     = BrPC[PC_W-1:0];
  assign misaligned = (BrPC[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    trap_d  = trap_q;
    accept  = 1'b0;
    // Flush counter free-runs down regardless of stall.
    fcnt_d  = (fcnt_q != 2'd0) ? fcnt_q - 2'd1 : 2'd0;

    case (state_q)
      RUN: begin
        if (PcSel) begin
          if (misaligned) begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end else begin
            accept = 1'b1;
            if (imem_ready) begin
              pc_d = target;
            end else begin
              pend_d  = target;
              state_d = REDIRECT;
            end
          end
        end else if (!Stall && imem_ready) begin
          pc_d = pc_q + c_pc_step;
        end
      end
      REDIRECT: begin
        if (PcSel) begin
          if (misaligned) begin
            state_d = TRAP;
            trap_d  = 1'b1;
          end else begin
            // Newest redirect replaces any parked target.
            accept = 1'b1;
            if (imem_ready) begin
              pc_d    = target;
              state_d = RUN;
            end else begin
              pend_d = target;
            end
          end
        end else if (imem_ready) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      TRAP: begin
        // Locked until reset.
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (accept) begin
      fcnt_d = c_flush_cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= c_reset_pc;
      pend_q  <= '0;
      fcnt_q  <= 2'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      trap_q  <= trap_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (accept && (rcnt_q != 16'hFFFF)) begin
      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= 16'd0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign RedirectCount = rcnt_q;
`else
  assign RedirectCount = 16'h0000;
`endif

  assign Cur_PC   = pc_q;
  assign imem_req = (state_q != TRAP);
  assign Flush    = (fcnt_q != 2'd0);
  assign Trap     = trap_q;

endmodule
`default_nettype wire
